// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and validates four raw coin-slot
// sensors, presenting accepted coins as a 4-bit value plus a one-cycle
// new_coin strobe, and refused events as a one-cycle reject strobe.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic [3:0] slot,
  input  logic       inhibit,
  output logic [3:0] coin,
  output logic       new_coin,
  output logic       reject,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    QUALIFY      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       s_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       coin_q;
  logic             new_coin_q;
  logic             reject_q;

  logic             cand_onehot_c;
  logic [3:0]       cand_value_c;

  // Two-flop synchroniser for the asynchronous sensor inputs.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= slot;
      s_q     <= sync1_q;
    end
  end

  // Decode the candidate pattern: only a single active sensor is a coin.
  always_comb begin
    cand_onehot_c = 1'b1;
    cand_value_c  = 4'd0;
    case (cand_q)
      4'b0001: cand_value_c = 4'd1;
      4'b0010: cand_value_c = 4'd2;
      4'b0100: cand_value_c = 4'd5;
      4'b1000: cand_value_c = 4'd10;
      default: cand_onehot_c = 1'b0;
    endcase
  end

  // Debounce FSM: qualify a stable pattern, evaluate once, then wait for a
  // full quiet period before arming again.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      coin_q     <= '0;
      new_coin_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      new_coin_q <= 1'b0;
      reject_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_q != 4'd0) begin
            cand_q  <= s_q;
            cnt_q   <= '0;
            state_q <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (s_q != cand_q) begin
            // Bounce or pattern change: drop the event silently.
            state_q <= IDLE;
          end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q   <= '0;
            state_q <= WAIT_RELEASE;
            if (cand_onehot_c && !inhibit) begin
              new_coin_q <= 1'b1;
              coin_q     <= cand_value_c;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        WAIT_RELEASE: begin
          // Any sensor activity restarts the release period.
          if (s_q != 4'd0) begin
            cnt_q <= '0;
          end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          new_coin_q <= 1'b0;
          reject_q   <= 1'b0;
        end
      endcase
    end
  end

  assign coin     = coin_q;
  assign new_coin = new_coin_q;
  assign reject   = reject_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor with DEBOUNCE_CYCLES = 4: directed sensor
// patterns push expected strobes into a queue; a monitor pops and compares.
module tb_coin_acceptor;

  logic       clk50m = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] slot   = 4'd0;
  logic       inhibit = 1'b0;
  logic [3:0] coin;
  logic       new_coin;
  logic       reject;
  logic       busy;

  typedef struct {
    logic       rej;
    logic [3:0] coin;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   e0    = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk50m   (clk50m),
    .rst      (rst),
    .slot     (slot),
    .inhibit  (inhibit),
    .coin     (coin),
    .new_coin (new_coin),
    .reject   (reject),
    .busy     (busy)
  );

  always #5 clk50m = ~clk50m;

  // Posedge counter; at a negedge it equals the number of edges seen.
  always @(posedge clk50m) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk50m) begin
    exp_t e;
    if (new_coin || reject) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: cyc=%0d new_coin=%b reject=%b coin=%0d, required no strobe",
                 cyc, new_coin, reject, coin);
      end else begin
        e = exp_q.pop_front();
        if (new_coin !== !e.rej || reject !== e.rej || coin !== e.coin || cyc != e.cyc) begin
          n_err++;
          $display("FAIL strobe: got new_coin=%b reject=%b coin=%0d cyc=%0d, required new_coin=%b reject=%b coin=%0d cyc=%0d",
                   new_coin, reject, coin, cyc, !e.rej, e.rej, e.coin, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  // Drive a pattern; the following posedge is relative edge 0.
  task automatic start(input logic [3:0] p);
    @(negedge clk50m);
    slot = p;
    e0   = cyc + 1;
  endtask

  // Advance to the negedge just after relative edge k.
  task automatic at_edge(input int k);
    while (cyc < e0 + k) @(negedge clk50m);
  endtask

  task automatic expect_strobe(input logic rej, input logic [3:0] c, input int k);
    exp_t e;
    e.rej  = rej;
    e.coin = c;
    e.cyc  = e0 + k;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk50m);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (3) @(negedge clk50m);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk50m);
    rst = 1'b0;
    check("rst_coin", coin, 4'd0);
    check("rst_new_coin", 4'(new_coin), 4'd0);
    check("rst_reject", 4'(reject), 4'd0);
    check("rst_busy", 4'(busy), 4'd0);

    // 1: 5-coin, busy timing through qualify and release
    start(4'b0100);
    expect_strobe(1'b0, 4'd5, 6);
    at_edge(1);  check("t1_busy_e1", 4'(busy), 4'd0);
    at_edge(2);  check("t1_busy_e2", 4'(busy), 4'd1);
    at_edge(9);  slot = 4'd0;
    at_edge(14); check("t1_busy_e14", 4'(busy), 4'd1);
    at_edge(15); check("t1_busy_e15", 4'(busy), 4'd0);
    check("t1_coin_hold", coin, 4'd5);
    wait_idle();

    // 2: bounce on the 1-coin sensor, accepted after the last rise
    start(4'b0001);
    at_edge(1);  slot = 4'd0;
    at_edge(2);  slot = 4'b0001;
    expect_strobe(1'b0, 4'd1, 9);
    at_edge(12); slot = 4'd0;
    wait_idle();

    // 3: two sensors at once -> reject, coin unchanged
    start(4'b0011);
    expect_strobe(1'b1, 4'd1, 6);
    at_edge(10); slot = 4'd0;
    wait_idle();
    check("t3_coin_hold", coin, 4'd1);

    // 4: inhibited 10-coin rejected, then accepted when not inhibited
    inhibit = 1'b1;
    start(4'b1000);
    expect_strobe(1'b1, 4'd1, 6);
    at_edge(10); slot = 4'd0;
    wait_idle();
    inhibit = 1'b0;
    start(4'b1000);
    expect_strobe(1'b0, 4'd10, 6);
    at_edge(10); slot = 4'd0;
    wait_idle();

    // 5: held sensor gives one strobe; a glitch restarts the release timer
    start(4'b0010);
    expect_strobe(1'b0, 4'd2, 6);
    at_edge(100); slot = 4'd0;
    at_edge(103); slot = 4'b0001;
    at_edge(104); slot = 4'd0;
    at_edge(106); check("t5_busy_restart", 4'(busy), 4'd1);
    at_edge(109); check("t5_busy_e109", 4'(busy), 4'd1);
    at_edge(110); check("t5_busy_e110", 4'(busy), 4'd0);
    wait_idle();

    // 6: reset mid-qualify aborts the event; a clean coin is accepted after
    start(4'b0001);
    at_edge(3); check("t6_busy_qual", 4'(busy), 4'd1);
    at_edge(4); rst = 1'b1; slot = 4'd0;
    at_edge(5); rst = 1'b0;
    check("t6_rst_busy", 4'(busy), 4'd0);
    check("t6_rst_coin", coin, 4'd0);
    check("t6_rst_new_coin", 4'(new_coin), 4'd0);
    at_edge(12); check("t6_busy_after", 4'(busy), 4'd0);
    start(4'b0001);
    expect_strobe(1'b0, 4'd1, 6);
    at_edge(10); slot = 4'd0;
    wait_idle();

    repeat (5) @(negedge clk50m);
    check("queue_empty", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
